// File: rtl/pokey_serout_ctrl.sv
// pokey_serout_ctrl: SEROUT holding register and frame sequencer for an external load/shift cell chain.
// Frames are start(0), DATA_W data bits LSB-first, stop(1); the chain shifts in 1s so the line idles at mark.
module pokey_serout_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enp,
    input  logic              bit_tick,
    input  logic              ser_wr,
    input  logic [DATA_W-1:0] ser_data,
    input  logic              force_break,
    input  logic              sr_q0,
    output logic              sr_load,
    output logic              sr_shift,
    output logic [DATA_W+1:0] sr_din,
    output logic              sod,
    output logic              irq_hold_empty,
    output logic              xmit_done
);
    localparam int CW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] LAST = CW'(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic              irq_q;
    logic              tick;
    logic              at_stop;

    always_comb begin
        tick     = enp && bit_tick;
        at_stop  = bitcnt_q == LAST;
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        if (state_q == IDLE) begin
            sr_load  = enp && hold_full_q;
            sr_shift = tick && !hold_full_q;
        end else if (tick) begin
            sr_load  = at_stop && hold_full_q;
            sr_shift = !(at_stop && hold_full_q);
        end
        if (sr_load) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
        end else if (sr_shift && state_q == SHIFT) begin
            state_d  = at_stop ? IDLE : SHIFT;
            bitcnt_d = at_stop ? '0 : bitcnt_q + CW'(1);
        end
        // a write in the load cycle re-arms the holding register
        hold_d      = ser_wr ? ser_data : hold_q;
        hold_full_d = ser_wr || (hold_full_q && !sr_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bitcnt_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bitcnt_q    <= bitcnt_d;
            irq_q       <= sr_load;
        end
    end

    assign sr_din         = {1'b1, hold_q, 1'b0};
    assign sod            = force_break ? 1'b0 : sr_q0;
    assign irq_hold_empty = irq_q;
    assign xmit_done      = (state_q == IDLE) && !hold_full_q;
endmodule

// File: tb/tb_pokey_serout_ctrl.sv
// tb_pokey_serout_ctrl: directed bench for pokey_serout_ctrl with a behavioural load/shift chain.
module tb_pokey_serout_ctrl;
    localparam int DW = 8;
    localparam int N  = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enp = 1'b0;
    logic          bit_tick = 1'b0;
    logic          ser_wr = 1'b0;
    logic          force_break = 1'b0;
    logic [DW-1:0] ser_data = '0;
    logic          sr_load, sr_shift, sod, irq_hold_empty, xmit_done;
    logic [N-1:0]  sr_din;
    logic [N-1:0]  chain = '1;
    logic          ld = 1'b0;
    logic          sh = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            irq_cnt = 0;

    always #5 clk = ~clk;

    // external cell chain: never reset, top stage shifts in 1
    always @(posedge clk) begin
        if (sr_load) chain <= sr_din;
        else if (sr_shift) chain <= {1'b1, chain[N-1:1]};
        if (irq_hold_empty) irq_cnt <= irq_cnt + 1;
    end

    pokey_serout_ctrl #(.DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enp            (enp),
        .bit_tick       (bit_tick),
        .ser_wr         (ser_wr),
        .ser_data       (ser_data),
        .force_break    (force_break),
        .sr_q0          (chain[0]),
        .sr_load        (sr_load),
        .sr_shift       (sr_shift),
        .sr_din         (sr_din),
        .sod            (sod),
        .irq_hold_empty (irq_hold_empty),
        .xmit_done      (xmit_done)
    );

    task automatic cyc(input logic e, input logic t);
        enp = e;
        bit_tick = t;
        #2;
        ld = sr_load;
        sh = sr_shift;
        @(posedge clk);
        #1;
        enp = 1'b0;
        bit_tick = 1'b0;
        ser_wr = 1'b0;
    endtask

    task automatic qtick();
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
    endtask

    task automatic write(input logic [DW-1:0] d);
        ser_wr = 1'b1;
        ser_data = d;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL reset xmit_done: got %b want 1", xmit_done); end
        n_checks++; if (sr_load !== 1'b0) begin n_fail++; $display("FAIL reset sr_load: got %b want 0", sr_load); end
        n_checks++; if (sr_shift !== 1'b0) begin n_fail++; $display("FAIL reset sr_shift: got %b want 0", sr_shift); end
        n_checks++; if (irq_hold_empty !== 1'b0) begin n_fail++; $display("FAIL reset irq: got %b want 0", irq_hold_empty); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL reset release xmit_done: got %b want 1", xmit_done); end
    endtask

    task automatic test_single();
        logic [N-1:0] f = 10'b1_01010101_0;
        int irq0 = irq_cnt;
        write(8'h55);
        n_checks++; if (xmit_done !== 1'b0) begin n_fail++; $display("FAIL single pending xmit_done: got %b want 0", xmit_done); end
        for (int k = 0; k < N; k++) begin
            qtick();
            n_checks++; if (sod !== f[k]) begin n_fail++; $display("FAIL single sod bit%0d: got %b want %b", k, sod, f[k]); end
            n_checks++; if (ld !== (k == 0)) begin n_fail++; $display("FAIL single sr_load bit%0d: got %b want %b", k, ld, k == 0); end
            n_checks++; if (xmit_done !== 1'b0) begin n_fail++; $display("FAIL single busy xmit_done bit%0d: got %b want 0", k, xmit_done); end
            if (k == 0) begin
                n_checks++; if (irq_hold_empty !== 1'b1) begin n_fail++; $display("FAIL single irq after load: got %b want 1", irq_hold_empty); end
            end
        end
        qtick();
        n_checks++; if (sh !== 1'b1 || ld !== 1'b0) begin n_fail++; $display("FAIL single end strobes: load=%b shift=%b want 0/1", ld, sh); end
        n_checks++; if (sod !== 1'b1) begin n_fail++; $display("FAIL single mark: got %b want 1", sod); end
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL single done: got %b want 1", xmit_done); end
        n_checks++; if (irq_cnt - irq0 != 1) begin n_fail++; $display("FAIL single irq count: got %0d want 1", irq_cnt - irq0); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] f1 = 10'b1_10100011_0;
        logic [N-1:0] f2 = 10'b1_00001111_0;
        int irq0 = irq_cnt;
        write(8'hA3);
        for (int k = 0; k < N; k++) begin
            if (k == 4) write(8'h0F);
            qtick();
            n_checks++; if (sod !== f1[k]) begin n_fail++; $display("FAIL b2b first sod bit%0d: got %b want %b", k, sod, f1[k]); end
            n_checks++; if (ld !== (k == 0)) begin n_fail++; $display("FAIL b2b first sr_load bit%0d: got %b want %b", k, ld, k == 0); end
        end
        for (int k = 0; k < N; k++) begin
            qtick();
            n_checks++; if (sod !== f2[k]) begin n_fail++; $display("FAIL b2b second sod bit%0d: got %b want %b", k, sod, f2[k]); end
            n_checks++; if (ld !== (k == 0)) begin n_fail++; $display("FAIL b2b second sr_load bit%0d: got %b want %b", k, ld, k == 0); end
        end
        qtick();
        n_checks++; if (xmit_done !== 1'b1 || sod !== 1'b1) begin n_fail++; $display("FAIL b2b end: xmit_done=%b sod=%b want 1/1", xmit_done, sod); end
        n_checks++; if (irq_cnt - irq0 != 2) begin n_fail++; $display("FAIL b2b irq count: got %0d want 2", irq_cnt - irq0); end
    endtask

    task automatic test_overwrite_collision();
        logic [N-1:0] f1 = 10'b1_00100010_0;
        logic [N-1:0] f2 = 10'b1_01000100_0;
        int irq0 = irq_cnt;
        write(8'h11);
        write(8'h22);
        repeat (3) cyc(1'b0, 1'b0);
        ser_wr = 1'b1;
        ser_data = 8'h44;
        cyc(1'b1, 1'b1);
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL collide load: got %b want 1", ld); end
        for (int k = 0; k < N; k++) begin
            if (k > 0) qtick();
            n_checks++; if (sod !== f1[k]) begin n_fail++; $display("FAIL overwrite sod bit%0d: got %b want %b", k, sod, f1[k]); end
        end
        qtick();
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL collide hold_full kept: reload=%b want 1", ld); end
        for (int k = 0; k < N; k++) begin
            if (k > 0) qtick();
            n_checks++; if (sod !== f2[k]) begin n_fail++; $display("FAIL collide second sod bit%0d: got %b want %b", k, sod, f2[k]); end
        end
        qtick();
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL collide done: got %b want 1", xmit_done); end
        n_checks++; if (irq_cnt - irq0 != 2) begin n_fail++; $display("FAIL collide irq count: got %0d want 2", irq_cnt - irq0); end
    endtask

    task automatic test_enp_gating();
        logic [N-1:0] f = 10'b1_11000110_0;
        write(8'hC6);
        repeat (3) begin
            cyc(1'b0, 1'b1);
            n_checks++; if (ld !== 1'b0 || sh !== 1'b0) begin n_fail++; $display("FAIL gate idle strobes: load=%b shift=%b want 0/0", ld, sh); end
        end
        for (int k = 0; k < 3; k++) qtick();
        n_checks++; if (sod !== f[2]) begin n_fail++; $display("FAIL gate pre sod: got %b want %b", sod, f[2]); end
        repeat (5) begin
            cyc(1'b0, 1'b1);
            n_checks++; if (ld !== 1'b0 || sh !== 1'b0) begin n_fail++; $display("FAIL gate shift strobes: load=%b shift=%b want 0/0", ld, sh); end
            n_checks++; if (sod !== f[2]) begin n_fail++; $display("FAIL gate hold sod: got %b want %b", sod, f[2]); end
        end
        for (int k = 3; k < N; k++) begin
            qtick();
            n_checks++; if (sod !== f[k]) begin n_fail++; $display("FAIL gate sod bit%0d: got %b want %b", k, sod, f[k]); end
            n_checks++; if (xmit_done !== 1'b0) begin n_fail++; $display("FAIL gate early idle bit%0d: xmit_done=%b want 0", k, xmit_done); end
        end
        qtick();
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL gate done: got %b want 1", xmit_done); end
    endtask

    task automatic test_break_reset();
        logic [N-1:0] f = 10'b1_00001111_0;
        int irq0;
        write(8'h0F);
        qtick();
        qtick();
        n_checks++; if (sod !== f[1]) begin n_fail++; $display("FAIL break pre sod: got %b want %b", sod, f[1]); end
        force_break = 1'b1;
        #1;
        n_checks++; if (sod !== 1'b0) begin n_fail++; $display("FAIL break immediate sod: got %b want 0", sod); end
        for (int k = 2; k < 5; k++) begin
            qtick();
            n_checks++; if (sod !== 1'b0) begin n_fail++; $display("FAIL break sod bit%0d: got %b want 0", k, sod); end
        end
        force_break = 1'b0;
        #1;
        n_checks++; if (sod !== f[4]) begin n_fail++; $display("FAIL break release sod: got %b want %b", sod, f[4]); end
        qtick();
        n_checks++; if (sod !== f[5]) begin n_fail++; $display("FAIL break continue sod: got %b want %b", sod, f[5]); end
        write(8'h77);
        irq0 = irq_cnt;
        rst_n = 1'b0;
        #2;
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL midreset xmit_done: got %b want 1", xmit_done); end
        n_checks++; if (sr_load !== 1'b0 || sr_shift !== 1'b0) begin n_fail++; $display("FAIL midreset strobes: load=%b shift=%b want 0/0", sr_load, sr_shift); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            qtick();
            n_checks++; if (sh !== 1'b1 || ld !== 1'b0) begin n_fail++; $display("FAIL postreset fill tick%0d: load=%b shift=%b want 0/1", k, ld, sh); end
        end
        n_checks++; if (sod !== 1'b1) begin n_fail++; $display("FAIL postreset mark: got %b want 1", sod); end
        n_checks++; if (xmit_done !== 1'b1) begin n_fail++; $display("FAIL postreset done: got %b want 1", xmit_done); end
        n_checks++; if (irq_cnt != irq0) begin n_fail++; $display("FAIL postreset irq: got %0d extra want 0", irq_cnt - irq0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overwrite_collision();
        test_enp_gating();
        test_break_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
